// File: rtl/cpu_hazard_unit.sv
// Hazard and bypass controller for the Falcon pipeline: tracks in-flight destinations
// across NBYPASS post-decode stages plus a pending scoreboard for one variable-latency unit.
module cpu_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int NBYPASS  = 3,
    parameter int LAT_BITS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     p3_jump,
    input  logic                     p2_valid,
    input  logic [REG_BITS-1:0]      p2_reg_a,
    input  logic [REG_BITS-1:0]      p2_reg_b,
    input  logic                     p2_a_is_reg,
    input  logic                     p2_b_is_reg,
    input  logic [REG_BITS-1:0]      p2_reg_d,
    input  logic [LAT_BITS-1:0]      p2_ready,
    input  logic                     p2_long,
    input  logic                     div_done,
    input  logic [REG_BITS-1:0]      div_reg,
    output logic [NBYPASS-1:0]       p2_bypass_a,
    output logic [NBYPASS-1:0]       p2_bypass_b,
    output logic                     p2_pipeline_bubble,
    output logic                     p2_issue,
    output logic                     long_busy,
    output logic [2**REG_BITS-1:0]   pending
);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] reg_d;
        logic [LAT_BITS-1:0] ready;
    } stage_t;

    // stages[0] is p3 (youngest), stages[NBYPASS-1] is the oldest tracked stage.
    stage_t stages [NBYPASS];
    stage_t next_entry;

    logic [NBYPASS:0] match_a;
    logic [NBYPASS:0] match_b;
    logic             hazard_waw;
    logic             hazard_struct;
    logic             any_hazard;
    logic             long_issue;

    // Returns {hazard, bypass_onehot}. Only the youngest matching stage counts;
    // a matching stage whose result is not yet produced blocks instead of bypassing.
    function automatic logic [NBYPASS:0] match_src(input logic [REG_BITS-1:0] src,
                                                   input logic                is_reg);
        logic [NBYPASS:0] result;
        logic             found;
        result = '0;
        found  = 1'b0;
        if (is_reg && src != '0) begin
            for (int i = 0; i < NBYPASS; i++) begin
                if (!found && stages[i].valid && stages[i].reg_d == src) begin
                    found = 1'b1;
                    if (i >= int'(stages[i].ready))
                        result[i] = 1'b1;
                    else
                        result[NBYPASS] = 1'b1;
                end
            end
            if (pending[src])
                result[NBYPASS] = 1'b1;
        end
        return result;
    endfunction

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        match_a            = match_src(p2_reg_a, p2_a_is_reg);
        match_b            = match_src(p2_reg_b, p2_b_is_reg);
        p2_bypass_a        = match_a[NBYPASS-1:0];
        p2_bypass_b        = match_b[NBYPASS-1:0];
        hazard_waw         = (p2_reg_d != '0) && pending[p2_reg_d];
        hazard_struct      = p2_long && long_busy;
        any_hazard         = match_a[NBYPASS] || match_b[NBYPASS] || hazard_waw || hazard_struct;
        p2_pipeline_bubble = p2_valid && !p3_jump && any_hazard;
        p2_issue           = p2_valid && !p3_jump && !p2_pipeline_bubble && !stall;
        long_issue         = p2_issue && p2_long && (p2_reg_d != '0);

        // Long ops are tracked only by the scoreboard, never by the bypass stages.
        next_entry.valid   = p2_issue && (p2_reg_d != '0) && !p2_long;
        next_entry.reg_d   = p2_reg_d;
        next_entry.ready   = p2_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the stage array is only NBYPASS flops wide and its valid bits gate all matching, so it is reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NBYPASS; i++)
                stages[i] <= '0;
        end else if (!stall) begin
            for (int i = 1; i < NBYPASS; i++)
                stages[i] <= stages[i-1];
            stages[0] <= next_entry;
        end
    end

    // Completion is honoured even under stall; a same-cycle issue to the same register wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending   <= '0;
            long_busy <= 1'b0;
        end else begin
            if (div_done) begin
                pending[div_reg] <= 1'b0;
                long_busy        <= 1'b0;
            end
            if (long_issue) begin
                pending[p2_reg_d] <= 1'b1;
                long_busy         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Directed bench for cpu_hazard_unit: each task drives a scenario and checks outputs
// against hand-computed values between clock edges.
module tb_cpu_hazard_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        p3_jump;
    logic        p2_valid;
    logic [4:0]  p2_reg_a;
    logic [4:0]  p2_reg_b;
    logic        p2_a_is_reg;
    logic        p2_b_is_reg;
    logic [4:0]  p2_reg_d;
    logic [1:0]  p2_ready;
    logic        p2_long;
    logic        div_done;
    logic [4:0]  div_reg;
    logic [2:0]  p2_bypass_a;
    logic [2:0]  p2_bypass_b;
    logic        p2_pipeline_bubble;
    logic        p2_issue;
    logic        long_busy;
    logic [31:0] pending;

    int assertions = 0;
    int failures   = 0;

    cpu_hazard_unit #(.REG_BITS(5), .NBYPASS(3), .LAT_BITS(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .p3_jump            (p3_jump),
        .p2_valid           (p2_valid),
        .p2_reg_a           (p2_reg_a),
        .p2_reg_b           (p2_reg_b),
        .p2_a_is_reg        (p2_a_is_reg),
        .p2_b_is_reg        (p2_b_is_reg),
        .p2_reg_d           (p2_reg_d),
        .p2_ready           (p2_ready),
        .p2_long            (p2_long),
        .div_done           (div_done),
        .div_reg            (div_reg),
        .p2_bypass_a        (p2_bypass_a),
        .p2_bypass_b        (p2_bypass_b),
        .p2_pipeline_bubble (p2_pipeline_bubble),
        .p2_issue           (p2_issue),
        .long_busy          (long_busy),
        .pending            (pending)
    );

    always #5 clock = ~clock;

    // Inputs change at the falling edge and are checked 1 ns later, far from the rising edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic ais,
                         input logic [4:0] b, input logic bis, input logic [4:0] d,
                         input logic [1:0] rdy, input logic lng);
        p2_valid = v;   p2_reg_a = a; p2_a_is_reg = ais;
        p2_reg_b = b;   p2_b_is_reg = bis;
        p2_reg_d = d;   p2_ready = rdy; p2_long = lng;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; p3_jump = 1'b0; div_done = 1'b0; div_reg = 5'd0;
        idle();
        step(); #1;
        assertions++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending: got %h expected %h", pending, 32'h0); end
        assertions++; if (long_busy !== 1'b0) begin failures++; $display("FAIL reset_long_busy: got %b expected 0", long_busy); end
        assertions++; if ({p2_bypass_a, p2_bypass_b, p2_pipeline_bubble, p2_issue} !== 8'h00) begin
            failures++; $display("FAIL reset_outputs: got %b expected 00000000", {p2_bypass_a, p2_bypass_b, p2_pipeline_bubble, p2_issue}); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 2'd0, 1'b0); #1;
        assertions++; if (p2_issue !== 1'b1) begin failures++; $display("FAIL b2b_writer_issue: got %b expected 1", p2_issue); end
        step(); drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); #1;
        assertions++; if (p2_bypass_a !== 3'b001) begin failures++; $display("FAIL b2b_bypass_p3: got %b expected 001", p2_bypass_a); end
        assertions++; if (p2_pipeline_bubble !== 1'b0) begin failures++; $display("FAIL b2b_no_bubble: got %b expected 0", p2_pipeline_bubble); end
        step(); #1;
        assertions++; if (p2_bypass_a !== 3'b010) begin failures++; $display("FAIL b2b_bypass_p4: got %b expected 010", p2_bypass_a); end
        step(); #1;
        assertions++; if (p2_bypass_a !== 3'b100) begin failures++; $display("FAIL b2b_bypass_p5: got %b expected 100", p2_bypass_a); end
        step(); #1;
        assertions++; if (p2_bypass_a !== 3'b000) begin failures++; $display("FAIL b2b_dropped: got %b expected 000", p2_bypass_a); end
    endtask

    task automatic test_load_use();
        step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 2'd1, 1'b0);
        step(); drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 2'd0, 1'b0); #1;
        assertions++; if ({p2_pipeline_bubble, p2_issue, p2_bypass_b} !== 5'b10000) begin
            failures++; $display("FAIL load_use_bubble: got %b expected 10000", {p2_pipeline_bubble, p2_issue, p2_bypass_b}); end
        step(); #1;
        assertions++; if ({p2_pipeline_bubble, p2_issue, p2_bypass_b} !== 5'b01010) begin
            failures++; $display("FAIL load_use_bypass: got %b expected 01010", {p2_pipeline_bubble, p2_issue, p2_bypass_b}); end
        step(); idle(); step(); step(); step();
    endtask

    task automatic test_youngest();
        step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 2'd0, 1'b0);
        step();
        step(); drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 2'd0, 1'b0); #1;
        assertions++; if (p2_bypass_a !== 3'b001) begin failures++; $display("FAIL youngest_a: got %b expected 001", p2_bypass_a); end
        assertions++; if ({p2_bypass_b, p2_pipeline_bubble} !== 4'b0000) begin
            failures++; $display("FAIL reg0_source: got %b expected 0000", {p2_bypass_b, p2_pipeline_bubble}); end
        step(); idle(); step(); step(); step();
    endtask

    task automatic test_stall();
        step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 2'd0, 1'b0);
        step(); drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); stall = 1'b1; #1;
        assertions++; if ({p2_bypass_a, p2_issue, p2_pipeline_bubble} !== 5'b00100) begin
            failures++; $display("FAIL stall_hold: got %b expected 00100", {p2_bypass_a, p2_issue, p2_pipeline_bubble}); end
        step(); stall = 1'b0; #1;
        assertions++; if ({p2_bypass_a, p2_issue} !== 4'b0011) begin
            failures++; $display("FAIL stall_release: got %b expected 0011", {p2_bypass_a, p2_issue}); end
        step(); idle(); step(); step(); step();
    endtask

    task automatic test_divider();
        step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 2'd0, 1'b1); #1;
        assertions++; if (p2_issue !== 1'b1) begin failures++; $display("FAIL div_issue: got %b expected 1", p2_issue); end
        step(); drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); #1;
        assertions++; if ({pending, long_busy} !== {32'h200, 1'b1}) begin
            failures++; $display("FAIL div_pending_set: got %h/%b expected 00000200/1", pending, long_busy); end
        assertions++; if ({p2_pipeline_bubble, p2_issue, p2_bypass_a} !== 5'b10000) begin
            failures++; $display("FAIL div_raw: got %b expected 10000", {p2_pipeline_bubble, p2_issue, p2_bypass_a}); end
        step(); #1;
        assertions++; if (p2_pipeline_bubble !== 1'b1) begin failures++; $display("FAIL div_raw_hold: got %b expected 1", p2_pipeline_bubble); end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 2'd0, 1'b0); #1;
        assertions++; if (p2_pipeline_bubble !== 1'b1) begin failures++; $display("FAIL div_waw: got %b expected 1", p2_pipeline_bubble); end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 2'd0, 1'b1); #1;
        assertions++; if (p2_pipeline_bubble !== 1'b1) begin failures++; $display("FAIL div_structural: got %b expected 1", p2_pipeline_bubble); end
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); div_done = 1'b1; div_reg = 5'd9; #1;
        assertions++; if (p2_pipeline_bubble !== 1'b1) begin failures++; $display("FAIL div_done_cycle: got %b expected 1", p2_pipeline_bubble); end
        step(); div_done = 1'b0; #1;
        assertions++; if ({p2_pipeline_bubble, p2_issue, p2_bypass_a} !== 5'b01000) begin
            failures++; $display("FAIL div_reader_go: got %b expected 01000", {p2_pipeline_bubble, p2_issue, p2_bypass_a}); end
        assertions++; if ({pending, long_busy} !== {32'h0, 1'b0}) begin
            failures++; $display("FAIL div_cleared: got %h/%b expected 00000000/0", pending, long_busy); end
    endtask

    task automatic test_back_to_back_long();
        step(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 2'd0, 1'b1); div_done = 1'b1; div_reg = 5'd9; #1;
        assertions++; if (p2_issue !== 1'b1) begin failures++; $display("FAIL same_cycle_issue: got %b expected 1", p2_issue); end
        step(); div_done = 1'b0; idle(); #1;
        assertions++; if ({pending, long_busy} !== {32'h200, 1'b1}) begin
            failures++; $display("FAIL set_wins: got %h/%b expected 00000200/1", pending, long_busy); end
        stall = 1'b1; div_done = 1'b1; div_reg = 5'd0;
        step(); stall = 1'b0; div_done = 1'b0; #1;
        assertions++; if ({pending, long_busy} !== {32'h200, 1'b0}) begin
            failures++; $display("FAIL done_reg0_under_stall: got %h/%b expected 00000200/0", pending, long_busy); end
    endtask

    task automatic test_jump();
        step(); drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 2'd0, 1'b0); p3_jump = 1'b1; #1;
        assertions++; if ({p2_pipeline_bubble, p2_issue} !== 2'b00) begin
            failures++; $display("FAIL jump_squash: got %b expected 00", {p2_pipeline_bubble, p2_issue}); end
        step(); p3_jump = 1'b0; drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0); #1;
        assertions++; if ({p2_bypass_a, p2_pipeline_bubble} !== 4'b0000) begin
            failures++; $display("FAIL jump_no_entry: got %b expected 0000", {p2_bypass_a, p2_pipeline_bubble}); end
    endtask

    task automatic test_reset_mid();
        step(); idle(); #1;
        assertions++; if (pending !== 32'h200) begin failures++; $display("FAIL pre_reset_pending: got %h expected 00000200", pending); end
        reset = 1'b1; div_done = 1'b1; div_reg = 5'd3;
        step(); #1;
        assertions++; if ({pending, long_busy} !== {32'h0, 1'b0}) begin
            failures++; $display("FAIL mid_reset: got %h/%b expected 00000000/0", pending, long_busy); end
        reset = 1'b0; div_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest();
        test_stall();
        test_divider();
        test_back_to_back_long();
        test_jump();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/cpu_hazard_unit.md
Name: cpu_hazard_unit

Overview:
- Parametrised hazard and bypass controller for the Falcon pipeline. It generalises the fixed p3/p4 bypass and load-use bubble logic.
- Tracks destination registers in flight across NBYPASS post-decode stages (p3..p(2+NBYPASS)), each with its own result-ready stage.
- Adds a pending-register scoreboard for one variable-latency unit (divider). Detects RAW and WAW hazards against that unit.
- Sits beside cpu_decoder. Drives the datamux bypass selects and the decode-stage bubble.

Parameters:
- REG_BITS, 5, register index width; the register file has 2**REG_BITS entries and register 0 is hardwired zero.
- NBYPASS, 3, number of tracked stages after decode (p3..p(2+NBYPASS)), each of which can bypass.
- LAT_BITS, 2, width of the ready-offset field.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  global pipeline freeze; no state advances
- p3_jump  input  1  the branch in p3 is taken; the p2 instruction is squashed
- p2_valid  input  1  p2 holds a real instruction
- p2_reg_a  input  REG_BITS  source A index
- p2_reg_b  input  REG_BITS  source B index
- p2_a_is_reg  input  1  source A is read from a register
- p2_b_is_reg  input  1  source B is read from a register
- p2_reg_d  input  REG_BITS  destination index; 0 means no write
- p2_ready  input  LAT_BITS  result is first bypassable in stage p(3+p2_ready)
- p2_long  input  1  instruction issues to the variable-latency unit
- div_done  input  1  the variable-latency unit writes back this cycle
- div_reg  input  REG_BITS  destination of that writeback
- p2_bypass_a  output  NBYPASS  one-hot; bit i selects the stage p(3+i) result for A; all zero means read the register file
- p2_bypass_b  output  NBYPASS  same for B
- p2_pipeline_bubble  output  1  hold p2 and insert a NOP into p3
- p2_issue  output  1  the p2 instruction advances into p3 this cycle
- long_busy  output  1  the variable-latency unit is occupied
- pending  output  2**REG_BITS  scoreboard bit per register

Behaviour:
- State:
  - Stage array s[0..NBYPASS-1] of {valid, reg_d, ready}.
  - Pending vector.
  - long_busy flag.
- Reset: all s.valid=0, pending=0, long_busy=0. All outputs read 0 in the cycle after reset is asserted. Reset mid-operation discards everything in flight and any divider completion is ignored.
- Outputs are combinational from the current state and the p2 inputs (zero-cycle latency). State updates on the rising edge only when stall=0.
- Source match for source X, where X is A or B:
  - X_is_reg=1 and X!=0.
  - Take the youngest valid stage i with s[i].reg_d==X.
  - A match at p(3+i) that has a valid tracked entry: the match is ready if i >= s[i].ready.
  - Ready match: bypass bit i=1. Not-ready match: hazard, bypass bits all 0.
  - Only the youngest match is considered; older matches are ignored.
- Scoreboard hazard:
  - RAW: pending[X]=1 for an active source.
  - WAW: pending[p2_reg_d]=1 with p2_reg_d!=0.
  - Structural: p2_long=1 with long_busy=1.
- p2_pipeline_bubble = p2_valid & !p3_jump & (any hazard).
- p2_issue = p2_valid & !p3_jump & !bubble & !stall.
- On each clock edge with stall=0:
  - s shifts: s[i+1]<=s[i].
  - s[0] loads {p2_issue & p2_reg_d!=0 & !p2_long, p2_reg_d, p2_ready}, otherwise valid=0.
  - Entries leaving s[NBYPASS-1] are dropped.
  - Long ops never enter s; their results come only through the pending scoreboard and the register file.
- Scoreboard update:
  - On p2_issue & p2_long & p2_reg_d!=0: pending[p2_reg_d]<=1 and long_busy<=1.
  - div_done=1 clears pending[div_reg] and long_busy. This happens even when stall=1; completion is never lost.
  - If div_done and a new long issue hit the same register in the same cycle, set wins.
  - div_done with div_reg=0 only clears long_busy.
- p3_jump: the p2 instruction is discarded with no bubble. Entries already in s are older and continue.
- Stall has priority over everything except reset and div_done.

Test Plan:
- Back-to-back ALU: r3 written with ready=0, next instruction reads r3 as A -> p2_bypass_a=3'b001, no bubble; one cycle later -> 3'b010.
- Load-use: load r5 with ready=1, next instruction reads r5 as B -> bubble for 1 cycle, then p2_bypass_b=3'b010, p2_issue=1.
- Youngest wins: r7 written at p4 and at p3 -> p2_bypass_a=3'b001 only. Register 0 read as a source -> bypass 0, no bubble.
- Divider: long op to r9, then a reader of r9 -> bubble until div_done with div_reg=9; the reader issues the next cycle with bypass=0, pending[9]=0.
- Second long op while long_busy=1 -> bubble. div_done in the same cycle as a new long issue to r9 -> pending[9]=1.
- p3_jump with a hazarding p2 -> bubble=0, p2_issue=0, s[0].valid=0. Reset asserted with pending=0x200 -> pending=0 and long_busy=0 on the next cycle.
